// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory access sequencer.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BEAT0,
    ST_BEAT1,
    ST_DONE,
    ST_RESP
  } state_e;

  localparam int unsigned DMEM_DEPTH_W = 9;
  localparam logic [31:0] DMEM_BASE    = 32'h0000_0000;
  localparam logic [31:0] DMEM_LIMIT   = DMEM_BASE + (32'd4 << DMEM_DEPTH_W) - 32'd1;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    size_e       size;
    logic        wren;
    logic        sgn;
  } req_t;

  // Any address bit above the word index means the access is outside DMEM.
  function automatic logic addr_oor(input logic [31:0] addr, input int unsigned depth_w);
    return (addr >> (depth_w + 2)) != 32'd0;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane math: lane enables, per-beat store data, load assembly and extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  off,
  input  size_e       size,
  input  logic [31:0] wdata,
  input  logic [31:0] lo,
  input  logic [23:0] hi,
  input  logic        sgn,
  output logic [7:0]  lanes,
  output logic [31:0] wdata0,
  output logic [31:0] wdata1,
  output logic [31:0] ld_data
);

  logic [7:0]  base_mask;
  logic [63:0] wshift;
  logic [31:0] asm_v;

  always_comb begin
    case (size)
      SZ_BYTE: base_mask = 8'h01;
      SZ_HALF: base_mask = 8'h03;
      default: base_mask = 8'h0F;
    endcase
    lanes  = base_mask << off;
    wshift = {32'd0, wdata} << {off, 3'b000};
    wdata0 = wshift[31:0];
    wdata1 = wshift[63:32];
    // The top byte of the high beat is never needed for a <= 4-byte access.
    case (off)
      2'd0:    asm_v = lo;
      2'd1:    asm_v = {hi[7:0],  lo[31:8]};
      2'd2:    asm_v = {hi[15:0], lo[31:16]};
      default: asm_v = {hi[23:0], lo[31:24]};
    endcase
    case (size)
      SZ_BYTE: ld_data = {{24{sgn & asm_v[7]}},  asm_v[7:0]};
      SZ_HALF: ld_data = {{16{sgn & asm_v[15]}}, asm_v[15:0]};
      default: ld_data = asm_v;
    endcase
  end

endmodule

// File: rtl/dmem_access_seq.sv
// Load/store sequencer: splits unaligned accesses into two aligned beats on a 1-cycle sync-read DMEM.
module dmem_access_seq
  import dmem_pkg::*;
#(
  parameter int DEPTH_W = DMEM_DEPTH_W
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic [31:0]        i_req_addr,
  input  logic [31:0]        i_req_wdata,
  input  logic [1:0]         i_req_size,
  input  logic               i_req_wren,
  input  logic               i_req_signed,
  output logic               o_rsp_valid,
  output logic [31:0]        o_rsp_rdata,
  output logic               o_rsp_split,
  output logic               o_rsp_err,
  output logic [DEPTH_W-1:0] o_mem_addr,
  output logic [31:0]        o_mem_wdata,
  output logic [3:0]         o_mem_bmask,
  output logic               o_mem_wren,
  input  logic [31:0]        i_mem_rdata
);

  state_e              state, state_d;
  req_t                req_q;
  logic [31:0]         lo_q, wdata_q;
  logic [DEPTH_W-1:0]  addr_q, word;
  logic [7:0]          lanes;
  logic [31:0]         wdata0, wdata1, ld_data, lo_v;
  logic [23:0]         hi_v;
  logic                split, err;

  assign word  = req_q.addr[DEPTH_W+1:2];
  assign split = |lanes[7:4];
  assign err   = addr_oor(req_q.addr, DEPTH_W);
  // In DONE the live read data is the low beat for single-beat accesses, the high beat otherwise.
  assign lo_v  = split ? lo_q : i_mem_rdata;
  assign hi_v  = split ? i_mem_rdata[23:0] : '0;

  dmem_lane_align u_align (
    .off     (req_q.addr[1:0]),
    .size    (req_q.size),
    .wdata   (req_q.wdata),
    .lo      (lo_v),
    .hi      (hi_v),
    .sgn     (req_q.sgn),
    .lanes   (lanes),
    .wdata0  (wdata0),
    .wdata1  (wdata1),
    .ld_data (ld_data)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= state_d;
  end

  always_comb begin
    state_d     = state;
    o_req_ready = 1'b0;
    o_mem_addr  = addr_q;
    o_mem_wdata = wdata_q;
    o_mem_bmask = 4'b0000;
    o_mem_wren  = 1'b0;
    case (state)
      ST_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) state_d = addr_oor(i_req_addr, DEPTH_W) ? ST_DONE : ST_BEAT0;
      end
      ST_BEAT0: begin
        o_mem_addr  = word;
        o_mem_bmask = lanes[3:0];
        o_mem_wdata = wdata0;
        o_mem_wren  = req_q.wren;
        state_d     = split ? ST_BEAT1 : ST_DONE;
      end
      ST_BEAT1: begin
        o_mem_addr  = word + DEPTH_W'(1);
        o_mem_bmask = lanes[7:4];
        o_mem_wdata = wdata1;
        o_mem_wren  = req_q.wren;
        state_d     = ST_DONE;
      end
      ST_DONE: state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      req_q       <= '0;
      lo_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      o_rsp_valid <= 1'b0;
      o_rsp_rdata <= '0;
      o_rsp_split <= 1'b0;
      o_rsp_err   <= 1'b0;
    end else begin
      addr_q      <= o_mem_addr;
      wdata_q     <= o_mem_wdata;
      o_rsp_valid <= (state == ST_DONE);
      o_rsp_split <= (state == ST_DONE) && split && !err;
      o_rsp_err   <= (state == ST_DONE) && err;
      o_rsp_rdata <= (state == ST_DONE && !err && !req_q.wren) ? ld_data : '0;
      if (state == ST_BEAT1) lo_q <= i_mem_rdata;
      if (state == ST_IDLE && i_req_valid)
        req_q <= '{addr: i_req_addr, wdata: i_req_wdata, size: size_e'(i_req_size),
                   wren: i_req_wren, sgn: i_req_signed};
    end
  end

endmodule

// File: tb/tb_dmem_access_seq.sv
// Scoreboard bench for dmem_access_seq with a behavioral byte-masked sync-read memory.
module tb_dmem_access_seq;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic [31:0] i_req_addr = '0;
  logic [31:0] i_req_wdata = '0;
  logic [1:0]  i_req_size = '0;
  logic        i_req_wren = 1'b0;
  logic        i_req_signed = 1'b0;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_split;
  logic        o_rsp_err;
  logic [8:0]  o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_bmask;
  logic        o_mem_wren;
  logic [31:0] i_mem_rdata;

  always #5 i_clk = ~i_clk;

  dmem_access_seq dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata), .i_req_size(i_req_size),
    .i_req_wren(i_req_wren), .i_req_signed(i_req_signed),
    .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata),
    .o_rsp_split(o_rsp_split), .o_rsp_err(o_rsp_err),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_bmask(o_mem_bmask),
    .o_mem_wren(o_mem_wren), .i_mem_rdata(i_mem_rdata)
  );

  logic [31:0] mem [0:511];
  logic [31:0] mem_nw;
  int          wr_count = 0;

  always @(posedge i_clk) begin
    if (o_mem_wren) begin
      mem_nw = mem[o_mem_addr];
      for (int b = 0; b < 4; b++)
        if (o_mem_bmask[b]) mem_nw[8*b +: 8] = o_mem_wdata[8*b +: 8];
      mem[o_mem_addr] <= mem_nw;
      wr_count <= wr_count + 1;
    end
    i_mem_rdata <= mem[o_mem_addr];
  end

  typedef struct {
    logic [31:0] rdata;
    logic        split;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          nb;
  logic [8:0]  b_addr [4];
  logic [3:0]  b_mask [4];
  logic [31:0] b_wdata[4];
  logic        b_wren [4];
  int          b_k    [4];

  function automatic logic [31:0] exp_load(input logic [31:0] d, input logic [1:0] sz, input logic sg);
    if (sz == 2'b00) return {{24{sg & d[7]}}, d[7:0]};
    if (sz == 2'b01) return {{16{sg & d[15]}}, d[15:0]};
    return d;
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  // Issue one request, record memory beats, pop and compare the response.
  task automatic do_req(input string tag, input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] sz, input logic we, input logic sg,
                        input logic [31:0] ex_rd, input logic ex_sp, input logic ex_er, input int ex_lat);
    exp_t e;
    bit   got = 0;
    e.rdata = ex_rd; e.split = ex_sp; e.err = ex_er; e.lat = ex_lat;
    sb.push_back(e);
    nb = 0;
    n_vec++;
    if (o_req_ready !== 1'b1) begin
      n_err++; $display("FAIL %s ready_before: got %b want 1", tag, o_req_ready);
    end
    i_req_valid = 1'b1; i_req_addr = a; i_req_wdata = wd; i_req_size = sz;
    i_req_wren = we; i_req_signed = sg;
    @(posedge i_clk); #1;
    i_req_valid = 1'b0; i_req_addr = $urandom; i_req_wdata = $urandom;
    i_req_size = 2'($urandom); i_req_wren = 1'($urandom); i_req_signed = 1'($urandom);
    for (int k = 1; k <= 10 && !got; k++) begin
      if (k == 1) begin
        n_vec++;
        if (o_req_ready !== 1'b0) begin
          n_err++; $display("FAIL %s ready_busy: got %b want 0", tag, o_req_ready);
        end
      end
      if (o_mem_bmask != 4'b0000 && nb < 4) begin
        b_addr[nb] = o_mem_addr; b_mask[nb] = o_mem_bmask; b_wdata[nb] = o_mem_wdata;
        b_wren[nb] = o_mem_wren; b_k[nb] = k; nb++;
      end
      if (o_rsp_valid === 1'b1) begin
        got = 1;
        e = sb.pop_front();
        n_vec++;
        if (k != e.lat) begin n_err++; $display("FAIL %s latency: got %0d want %0d", tag, k, e.lat); end
        n_vec++;
        if (o_rsp_rdata !== e.rdata) begin
          n_err++; $display("FAIL %s rdata: got %h want %h", tag, o_rsp_rdata, e.rdata);
        end
        n_vec++;
        if ({o_rsp_split, o_rsp_err} !== {e.split, e.err}) begin
          n_err++; $display("FAIL %s split/err: got %b%b want %b%b", tag, o_rsp_split, o_rsp_err, e.split, e.err);
        end
      end
      @(posedge i_clk); #1;
    end
    n_vec++;
    if (!got) begin
      n_err++; $display("FAIL %s timeout: no o_rsp_valid within 10 cycles", tag);
      e = sb.pop_front();
    end else if ({o_rsp_valid, o_req_ready} !== 2'b01) begin
      n_err++; $display("FAIL %s after_rsp: got valid/ready %b%b want 01", tag, o_rsp_valid, o_req_ready);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge i_clk);
    #1;
    n_vec++;
    if ({o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_split, o_rsp_err, o_mem_addr, o_mem_wdata, o_mem_bmask, o_mem_wren}
        !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 9'h0, 32'h0, 4'h0, 1'b0}) begin
      n_err++; $display("FAIL reset_outputs: ready=%b valid=%b rdata=%h addr=%h wdata=%h bmask=%b wren=%b want ready=1 rest 0",
                        o_req_ready, o_rsp_valid, o_rsp_rdata, o_mem_addr, o_mem_wdata, o_mem_bmask, o_mem_wren);
    end
    i_reset = 1'b0;
    @(posedge i_clk); #1;
    n_vec++;
    if ({o_req_ready, o_rsp_valid, o_mem_wren, o_mem_bmask} !== {1'b1, 1'b0, 1'b0, 4'h0}) begin
      n_err++; $display("FAIL reset_release: ready=%b valid=%b wren=%b bmask=%b want 1 0 0 0",
                        o_req_ready, o_rsp_valid, o_mem_wren, o_mem_bmask);
    end
  endtask

  task automatic test_aligned_word();
    do_req("sw_aligned", 32'h10, 32'hDEADBEEF, 2'b10, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 3);
    n_vec++;
    if (nb != 1 || {b_addr[0], b_mask[0], b_wdata[0], b_wren[0], 4'(b_k[0])} !== {9'd4, 4'b1111, 32'hDEADBEEF, 1'b1, 4'd1}) begin
      n_err++; $display("FAIL sw_aligned_beat: got n=%0d addr=%0d mask=%b wdata=%h wren=%b k=%0d want n=1 addr=4 mask=1111 wdata=deadbeef wren=1 k=1",
                        nb, b_addr[0], b_mask[0], b_wdata[0], b_wren[0], b_k[0]);
    end
    do_req("lw_aligned", 32'h10, 32'h0, 2'b10, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 3);
    n_vec++;
    if (nb != 1 || {b_addr[0], b_mask[0], b_wren[0]} !== {9'd4, 4'b1111, 1'b0}) begin
      n_err++; $display("FAIL lw_aligned_beat: got n=%0d addr=%0d mask=%b wren=%b want n=1 addr=4 mask=1111 wren=0",
                        nb, b_addr[0], b_mask[0], b_wren[0]);
    end
  endtask

  task automatic test_signed_byte();
    do_req("sw_pattern", 32'h10, 32'h80FF7F01, 2'b10, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 3);
    do_req("lb_13",  32'h13, 32'h0, 2'b00, 1'b0, 1'b1, 32'hFFFFFF80, 1'b0, 1'b0, 3);
    do_req("lbu_13", 32'h13, 32'h0, 2'b00, 1'b0, 1'b0, 32'h00000080, 1'b0, 1'b0, 3);
    do_req("lb_12",  32'h12, 32'h0, 2'b00, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 3);
    do_req("lb_11",  32'h11, 32'h0, 2'b00, 1'b0, 1'b1, 32'h0000007F, 1'b0, 1'b0, 3);
    do_req("lhu_10", 32'h10, 32'h0, 2'b01, 1'b0, 1'b0, 32'h00007F01, 1'b0, 1'b0, 3);
  endtask

  task automatic test_split_store();
    do_req("sw_split", 32'h0F, 32'h11223344, 2'b10, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 4);
    n_vec++;
    if (nb != 2 || {b_addr[0], b_mask[0], b_wdata[0], b_wren[0]} !== {9'd3, 4'b1000, 32'h44000000, 1'b1}) begin
      n_err++; $display("FAIL sw_split_beat0: got n=%0d addr=%0d mask=%b wdata=%h wren=%b want n=2 addr=3 mask=1000 wdata=44000000 wren=1",
                        nb, b_addr[0], b_mask[0], b_wdata[0], b_wren[0]);
    end
    n_vec++;
    if ({b_addr[1], b_mask[1], b_wdata[1], b_wren[1], 4'(b_k[1])} !== {9'd4, 4'b0111, 32'h00112233, 1'b1, 4'd2}) begin
      n_err++; $display("FAIL sw_split_beat1: got addr=%0d mask=%b wdata=%h wren=%b k=%0d want addr=4 mask=0111 wdata=00112233 wren=1 k=2",
                        b_addr[1], b_mask[1], b_wdata[1], b_wren[1], b_k[1]);
    end
    do_req("lw_split", 32'h0F, 32'h0, 2'b10, 1'b0, 1'b0, 32'h11223344, 1'b1, 1'b0, 4);
  endtask

  task automatic test_wrap_half();
    do_req("sb_7ff", 32'h7FF, 32'h000000AB, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 3);
    n_vec++;
    if (nb != 1 || {b_addr[0], b_mask[0], b_wdata[0]} !== {9'd511, 4'b1000, 32'hAB000000}) begin
      n_err++; $display("FAIL sb_7ff_beat: got n=%0d addr=%0d mask=%b wdata=%h want n=1 addr=511 mask=1000 wdata=ab000000",
                        nb, b_addr[0], b_mask[0], b_wdata[0]);
    end
    do_req("sb_000", 32'h000, 32'h00000080, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 3);
    do_req("lh_wrap", 32'h7FF, 32'h0, 2'b01, 1'b0, 1'b1, 32'hFFFF80AB, 1'b1, 1'b0, 4);
    n_vec++;
    if (nb != 2 || {b_addr[0], b_mask[0], b_addr[1], b_mask[1]} !== {9'd511, 4'b1000, 9'd0, 4'b0001}) begin
      n_err++; $display("FAIL lh_wrap_beats: got n=%0d %0d/%b %0d/%b want n=2 511/1000 0/0001",
                        nb, b_addr[0], b_mask[0], b_addr[1], b_mask[1]);
    end
    do_req("lhu_wrap", 32'h7FF, 32'h0, 2'b01, 1'b0, 1'b0, 32'h000080AB, 1'b1, 1'b0, 4);
  endtask

  task automatic test_err();
    int w0;
    w0 = wr_count;
    do_req("lw_oor", 32'h1000_0000, 32'h0, 2'b10, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 2);
    n_vec++;
    if (nb != 0) begin n_err++; $display("FAIL lw_oor_beats: got %0d beats want 0", nb); end
    do_req("sb_800", 32'h800, 32'h12345678, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 2);
    n_vec++;
    if (nb != 0 || wr_count != w0) begin
      n_err++; $display("FAIL sb_800_nowrite: got beats=%0d writes=%0d want 0 0", nb, wr_count - w0);
    end
    do_req("sw_7fc", 32'h7FC, 32'hA5A55A5A, 2'b10, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 3);
    do_req("lw_7fc", 32'h7FC, 32'h0, 2'b10, 1'b0, 1'b0, 32'hA5A55A5A, 1'b0, 1'b0, 3);
  endtask

  task automatic test_back_to_back();
    do_req("sw_sz3", 32'h20, 32'hCAFEF00D, 2'b11, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 3);
    do_req("lw_sz3", 32'h20, 32'h0, 2'b11, 1'b0, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0, 3);
    do_req("lh_22",  32'h22, 32'h0, 2'b01, 1'b0, 1'b1, 32'hFFFFCAFE, 1'b0, 1'b0, 3);
    do_req("lbu_21", 32'h21, 32'h0, 2'b00, 1'b0, 1'b0, 32'h000000F0, 1'b0, 1'b0, 3);
  endtask

  task automatic test_reset_mid();
    int w0;
    int seen = 0;
    i_req_valid = 1'b1; i_req_addr = 32'h2E; i_req_wdata = 32'h55667788;
    i_req_size = 2'b10; i_req_wren = 1'b1; i_req_signed = 1'b0;
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    n_vec++;
    if ({o_mem_wren, o_mem_addr, o_mem_bmask} !== {1'b1, 9'd11, 4'b1100}) begin
      n_err++; $display("FAIL rst_mid_beat0: got wren=%b addr=%0d mask=%b want 1 11 1100", o_mem_wren, o_mem_addr, o_mem_bmask);
    end
    w0 = wr_count;
    i_reset = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (o_rsp_valid !== 1'b0) seen++;
      @(posedge i_clk); #1;
    end
    n_vec++;
    if (seen != 0 || wr_count != w0 || o_req_ready !== 1'b1) begin
      n_err++; $display("FAIL rst_mid_abort: got rsp=%0d writes=%0d ready=%b want 0 0 1", seen, wr_count - w0, o_req_ready);
    end
    do_req("lw_after_rst", 32'h0F, 32'h0, 2'b10, 1'b0, 1'b0, 32'h11223344, 1'b1, 1'b0, 4);
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++) begin
      logic [31:0] a, d;
      logic [1:0]  sz;
      logic        sg, sp;
      a  = 32'($urandom_range(0, 2047));
      d  = $urandom;
      sz = 2'($urandom);
      sg = 1'($urandom);
      sp = (int'(a[1:0]) + nbytes(sz)) > 4;
      do_req("rnd_st", a, d, sz, 1'b1, 1'b0, 32'h0, sp, 1'b0, sp ? 4 : 3);
      do_req("rnd_ld", a, 32'h0, sz, 1'b0, sg, exp_load(d, sz, sg), sp, 1'b0, sp ? 4 : 3);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_aligned_word();
    test_signed_byte();
    test_split_store();
    test_wrap_half();
    test_err();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
